// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   state_t    : loader FSM encoding (S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE)
//   DATA_W_DEF : default instruction word width
//   BYTES      : bytes per instruction word at the default width
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int BYTES      = DATA_W_DEF / 8;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: packs a byte stream into big-endian words.
//   clk, rst        : clock, synchronous active-low reset
//   clr             : drop any partial word and restart at byte 0
//   byte_valid      : byte_in is consumed this cycle
//   byte_in         : stream byte, first byte lands in the MSB
//   word            : word as it will look once byte_in is shifted in
//   word_valid      : byte_in completes a word this cycle
module word_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int NB = BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [NB*8-1:0]   word,
  output logic              word_valid
);

  localparam int W  = NB * 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [W-1:0]  shreg;
  logic [IW-1:0] idx;

  // Combinational look-ahead so the top can register the complete word on
  // the same edge that accepts its last byte.
  assign word       = (shreg << 8) | W'(byte_in);
  assign word_valid = byte_valid && (idx == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      shreg <= '0;
      idx   <= '0;
    end else if (byte_valid) begin
      shreg <= word;
      idx   <= word_valid ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: run-time program load path into instruction memory.
// Receives LEN, then (LEN+1) big-endian words, then an XOR checksum byte,
// writing word k to address k while holding the CPU stalled.
//   clk, rst            : clock, synchronous active-low reset
//   start, abort        : begin a load (idle only) / cancel a load
//   in_data, in_valid   : byte stream input
//   in_ready            : byte accepted this cycle when in_valid is high
//   wr_en/addr/data     : instruction memory write port, one cycle per word
//   cpu_stall           : high while in LEN, DATA or CHK
//   done, err           : sticky status, cleared by the next start
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic              word_valid, last_word, asm_clr, asm_vld;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] len, word_cnt, addr_cnt;
  logic [7:0]        xor_acc;

  assign last_word = (word_cnt == len);
  // Returning to idle (normal end, abort or reset) throws away any partial word.
  assign asm_clr   = (state == S_IDLE);
  assign asm_vld   = (state == S_DATA) && in_valid && in_ready;

  word_assembler #(.NB(DATA_W / 8)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (asm_vld),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // An abort cycle never counts as a byte transfer, so in_ready drops with it.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_stall = 1'b0;
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_LEN;
      S_LEN: begin
        cpu_stall = 1'b1;
        in_ready  = !abort;
        if (abort)         state_nxt = S_IDLE;
        else if (in_valid) state_nxt = S_DATA;
      end
      S_DATA: begin
        cpu_stall = 1'b1;
        in_ready  = !abort;
        if (abort)                        state_nxt = S_IDLE;
        else if (word_valid && last_word) state_nxt = S_CHK;
      end
      S_CHK: begin
        cpu_stall = 1'b1;
        in_ready  = !abort;
        if (abort)         state_nxt = S_IDLE;
        else if (in_valid) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      len      <= '0;
      word_cnt <= '0;
      addr_cnt <= '0;
      xor_acc  <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: if (start && !abort) begin
          done     <= 1'b0;
          err      <= 1'b0;
          word_cnt <= '0;
          addr_cnt <= '0;
          xor_acc  <= '0;
        end
        S_LEN: begin
          if (abort)         err <= 1'b1;
          else if (in_valid) len <= ADDR_W'(in_data);
        end
        S_DATA: begin
          if (abort) err <= 1'b1;
          else if (in_valid) begin
            xor_acc <= xor_acc ^ in_data;
            if (word_valid) begin
              // wr_addr holds the address actually written; the counter
              // moves on so the last address stays visible after a full fill.
              wr_en    <= 1'b1;
              wr_addr  <= addr_cnt;
              wr_data  <= word;
              addr_cnt <= addr_cnt + 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_CHK: begin
          if (abort)         err <= 1'b1;
          else if (in_valid) err <= (in_data != xor_acc);
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: randomized byte streams against a
// frame-level behavioural model, plus literal end-of-test expectations.
module tb_instr_mem_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready, wr_en, cpu_stall, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_stall(cpu_stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame byte counting) ----------------
  bit                m_busy, m_indone, m_done, m_err, m_wr_en;
  int                m_nb, m_len, m_addr;
  logic [7:0]        m_xor;
  logic [DATA_W-1:0] m_word, m_wr_data;
  logic [ADDR_W-1:0] m_wr_addr;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0; m_indone = 0; m_done = 0; m_err = 0; m_wr_en = 0;
      m_nb = 0; m_len = 0; m_addr = 0; m_xor = '0; m_word = '0;
      m_wr_data = '0; m_wr_addr = '0;
    end else begin
      m_wr_en = 0;
      if (m_indone) begin
        m_indone = 0; m_done = 1;
      end else if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1; m_nb = 0; m_done = 0; m_err = 0; m_addr = 0; m_xor = '0;
        end
      end else if (abort) begin
        m_busy = 0; m_err = 1;
      end else if (in_valid) begin
        if (m_nb == 0) m_len = int'(in_data);
        else if (m_nb <= NB * (m_len + 1)) begin
          m_word = {m_word[DATA_W-9:0], in_data};
          m_xor  = m_xor ^ in_data;
          if (m_nb % NB == 0) begin
            m_wr_en = 1; m_wr_addr = ADDR_W'(m_addr); m_wr_data = m_word; m_addr++;
          end
        end else begin
          m_err = (in_data != m_xor); m_busy = 0; m_indone = 1;
        end
        m_nb++;
      end
    end
  end

  // ---------------- compare + write monitor ----------------
  bit                chk_en = 0;
  int                stall_cycles, nwrites;
  int                wcnt [DEPTH];
  logic [DATA_W-1:0] wdata[DEPTH];
  logic [DATA_W-1:0] sent [DEPTH];
  logic [ADDR_W-1:0] last_addr;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("in_ready", in_ready, m_busy && !abort);
      chk("cpu_stall", cpu_stall, m_busy);
      chk("wr_en", wr_en, m_wr_en);
      if (m_wr_en) begin
        chk("wr_addr", wr_addr, m_wr_addr);
        chk("wr_data", wr_data, m_wr_data);
      end
      chk("done", done, m_done);
      chk("err", err, m_err);
    end
    if (cpu_stall === 1'b1) stall_cycles++;
    if (wr_en === 1'b1) begin
      nwrites++; wcnt[wr_addr]++; wdata[wr_addr] = wr_data; last_addr = wr_addr;
    end
  end

  task automatic clear_stats();
    stall_cycles = 0; nwrites = 0;
    for (int i = 0; i < DEPTH; i++) wcnt[i] = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); in_valid = 0; start = 0; abort = 0;
    end
  endtask

  function automatic int gapv(input int gm);
    if (gm == 1) return 1;
    if (gm == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) idle(gap);
    @(negedge clk); start = 0; abort = 0; in_valid = 1; in_data = b;
    #1;
    while (!in_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("send_ready", in_ready, 1);
    if (in_ready) @(posedge clk);
    else in_valid = 0;
    #1;
  endtask

  task automatic load(input int len, input bit bad, input int gm);
    logic [7:0] x, b;
    x = '0;
    @(negedge clk); start = 1;
    send(8'(len), gapv(gm));
    for (int w = 0; w <= len; w++)
      for (int k = 0; k < NB; k++) begin
        b = 8'($urandom);
        sent[w] = {sent[w][DATA_W-9:0], b};
        x = x ^ b;
        send(b, gapv(gm));
      end
    send(bad ? (x ^ 8'h5A) : x, gapv(gm));
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    // 1) reset for two cycles, then idle without start
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk);
    @(negedge clk); #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1;
    idle(4); #3;
    chk("idle_stall", cpu_stall, 0);
    chk("idle_ready", in_ready, 0);
    chk("idle_done", done, 0);

    // 2) single word, good checksum
    clear_stats();
    @(negedge clk); start = 1;
    send(8'h00, 0); send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    send(8'h08, 0);
    idle(3); #3;
    chk("t2_nwrites", nwrites, 1);
    chk("t2_addr0", wcnt[0], 1);
    chk("t2_data", wdata[0], 32'h12345678);
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    chk("t2_stall_cycles", stall_cycles, 6);

    // 3) three words, in_valid toggled, bad checksum
    clear_stats();
    load(2, 1, 1); #3;
    chk("t3_nwrites", nwrites, 3);
    for (int w = 0; w < 3; w++) begin
      chk("t3_wcnt", wcnt[w], 1);
      chk("t3_data", wdata[w], sent[w]);
    end
    chk("t3_done", done, 1);
    chk("t3_err", err, 1);

    // 4) full memory fill, random gaps
    clear_stats();
    load(255, 0, 2); #3;
    chk("t4_nwrites", nwrites, 256);
    for (int a = 0; a < DEPTH; a++) chk("t4_wcnt", wcnt[a], 1);
    chk("t4_last_addr", last_addr, 8'hFF);
    chk("t4_last_data", wdata[255], sent[255]);
    chk("t4_done", done, 1);
    chk("t4_err", err, 0);

    // 5) abort after two bytes of word 1
    clear_stats();
    @(negedge clk); start = 1;
    send(8'h01, 0);
    repeat (NB + 2) send(8'($urandom), 0);
    @(negedge clk); abort = 1; in_valid = 0;
    idle(3); #3;
    chk("t5_nwrites", nwrites, 1);
    chk("t5_wcnt0", wcnt[0], 1);
    chk("t5_wcnt1", wcnt[1], 0);
    chk("t5_err", err, 1);
    chk("t5_done", done, 0);
    chk("t5_stall", cpu_stall, 0);
    // start together with abort in idle: no load, status untouched
    @(negedge clk); start = 1; abort = 1;
    idle(2); #3;
    chk("t5_sa_stall", cpu_stall, 0);
    chk("t5_sa_err", err, 1);

    // 6) reset mid-DATA, then clean reload
    clear_stats();
    @(negedge clk); start = 1;
    send(8'h00, 0); send(8'hAB, 0); send(8'hCD, 0);
    @(negedge clk); rst = 0; in_valid = 0;
    @(negedge clk); #3;
    chk("t6_rst_stall", cpu_stall, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    rst = 1;
    idle(2);
    clear_stats();
    load(0, 0, 0); #3;
    chk("t6_nwrites", nwrites, 1);
    chk("t6_wcnt0", wcnt[0], 1);
    chk("t6_data", wdata[0], sent[0]);
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
